// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of the issue, writeback-request and register-file write-port signals
// for the writeback scheduler; master drives requests, slave is the scheduler.
interface regfile_wb_scheduler_if #(
  parameter int NREQ = 3,
  parameter int NSRC = 3
);
  logic                issue_valid;
  logic [5:0]          issue_waddr;
  logic [NSRC*6-1:0]   issue_raddr;
  logic                issue_stall;
  logic                flush;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*6-1:0]   req_waddr;
  logic [NREQ*32-1:0]  req_wdata;
  logic [NREQ-1:0]     req_ready;
  logic                rf_we;
  logic [5:0]          rf_waddr;
  logic [31:0]         rf_wdata;
  logic [63:0]         busy;
  logic                wb_err;

  modport master (
    output issue_valid, issue_waddr, issue_raddr, flush,
    output req_valid, req_waddr, req_wdata,
    input  issue_stall, req_ready, rf_we, rf_waddr, rf_wdata, busy, wb_err
  );

  modport slave (
    input  issue_valid, issue_waddr, issue_raddr, flush,
    input  req_valid, req_waddr, req_wdata,
    output issue_stall, req_ready, rf_we, rf_waddr, rf_wdata, busy, wb_err
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin writeback arbiter for the scalar RF write port plus a 64-entry busy scoreboard.
// Latency: grant is combinational, the RF write is registered one cycle after the handshake.
// Backpressure: a requester holds valid until its one-hot ready; issue is held off by issue_stall.
module regfile_wb_scheduler #(
  parameter int NREQ = 3,
  parameter int NSRC = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  regfile_wb_scheduler_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] grant;
  logic            hs;
  logic [5:0]      sel_waddr;
  logic [31:0]     sel_wdata;

  logic [63:0] busy_q;
  logic [63:0] clr_mask;
  logic [63:0] set_mask;
  logic [63:0] busy_eff;
  logic [63:0] busy_nxt;
  logic        hazard;
  logic        accept;

  logic        rf_we_q;
  logic [5:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;
  logic        wb_err_q;

  // Two passes: first from rr_ptr to the top, then wrap from index 0.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    hs      = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!hs && bus.req_valid[i] && (i >= int'(rr_ptr))) begin
        grant[i] = 1'b1;
        gnt_idx  = PW'(i);
        hs       = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!hs && bus.req_valid[i]) begin
        grant[i] = 1'b1;
        gnt_idx  = PW'(i);
        hs       = 1'b1;
      end
    end
    if (!rstn) begin
      grant = '0;
      hs    = 1'b0;
    end
  end

  assign sel_waddr = bus.req_waddr[int'(gnt_idx)*6 +: 6];
  assign sel_wdata = bus.req_wdata[int'(gnt_idx)*32 +: 32];

  // The in-flight write is treated as already retired, matching the RF read bypass.
  always_comb begin
    clr_mask = rf_we_q ? (64'd1 << rf_waddr_q) : 64'd0;
    busy_eff = busy_q & ~clr_mask;
    hazard   = (bus.issue_waddr != 6'd0) && busy_eff[bus.issue_waddr];
    for (int i = 0; i < NSRC; i++) begin
      hazard = hazard | busy_eff[bus.issue_raddr[6*i +: 6]];
    end
    accept   = bus.issue_valid && !hazard;
    set_mask = accept ? (64'd1 << bus.issue_waddr) : 64'd0;
    busy_nxt = bus.flush ? 64'd0 : ((busy_q & ~clr_mask) | set_mask);
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 6'd0;
      rf_wdata_q <= 32'd0;
      busy_q     <= 64'd0;
      wb_err_q   <= 1'b0;
    end else begin
      rf_we_q <= hs && (sel_waddr != 6'd0);
      if (hs) begin
        rf_waddr_q <= sel_waddr;
        rf_wdata_q <= sel_wdata;
        rr_ptr     <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PW'(1);
      end
      busy_q <= busy_nxt;
      if (rf_we_q && !busy_q[rf_waddr_q] && !bus.flush) begin
        wb_err_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready   = grant;
  assign bus.issue_stall = bus.issue_valid && hazard;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign bus.busy        = busy_q;
  assign bus.wb_err      = wb_err_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: stimulus pushes expected grants and RF writes,
// a negedge monitor pops and compares them; cycle-level state is checked inline.
module tb_regfile_wb_scheduler;
  logic clk;
  logic rstn;
  int   n_vec;
  int   n_err;

  logic [2:0]  gq[$];
  logic [37:0] wq[$];

  regfile_wb_scheduler_if #(.NREQ(3), .NSRC(3)) bus ();

  regfile_wb_scheduler #(.NREQ(3), .NSRC(3)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented grant and every RF write must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.req_ready !== 3'b000 && bus.req_ready !== 3'bxxx) begin
      if (gq.size() == 0) chk("grant_unexpected", {61'd0, bus.req_ready}, 64'd0);
      else chk("grant", {61'd0, bus.req_ready}, {61'd0, gq.pop_front()});
    end
    if (bus.rf_we === 1'b1) begin
      if (wq.size() == 0) chk("write_unexpected", {26'd0, bus.rf_waddr, bus.rf_wdata}, 64'd0);
      else chk("write", {26'd0, bus.rf_waddr, bus.rf_wdata}, {26'd0, wq.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [5:0] d, input logic [5:0] s0,
                       input logic [5:0] s1, input logic [5:0] s2);
    bus.issue_valid = v;
    bus.issue_waddr = d;
    bus.issue_raddr = {s2, s1, s0};
  endtask

  task automatic set_req(input int i, input logic [5:0] a, input logic [31:0] d);
    bus.req_waddr[i*6 +: 6]   = a;
    bus.req_wdata[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.req_valid = '0;
    bus.flush = 1'b0;
    issue(1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
    @(negedge clk);
    chk("ready_in_reset", {61'd0, bus.req_ready}, 64'd0);
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn  = 1'b0;
    bus.req_waddr = '0;
    bus.req_wdata = '0;

    // 1: reset state, RAW on x5, writeback releases it
    do_reset();
    @(negedge clk);
    chk("rst_rf_we", {63'd0, bus.rf_we}, 64'd0);
    chk("rst_rf_waddr", {58'd0, bus.rf_waddr}, 64'd0);
    chk("rst_rf_wdata", {32'd0, bus.rf_wdata}, 64'd0);
    chk("rst_busy", bus.busy, 64'd0);
    chk("rst_wb_err", {63'd0, bus.wb_err}, 64'd0);
    tick();
    issue(1'b1, 6'd5, 6'd0, 6'd0, 6'd0);
    @(negedge clk);
    chk("issue_x5_stall", {63'd0, bus.issue_stall}, 64'd0);
    tick();
    issue(1'b1, 6'd10, 6'd5, 6'd0, 6'd0);
    @(negedge clk);
    chk("raw_x5_stall", {63'd0, bus.issue_stall}, 64'd1);
    chk("busy_x5", bus.busy, 64'd1 << 5);
    tick();
    set_req(0, 6'd5, 32'hDEADBEEF);
    bus.req_valid = 3'b001;
    gq.push_back(3'b001);
    wq.push_back({6'd5, 32'hDEADBEEF});
    @(negedge clk);
    chk("t1_ready", {61'd0, bus.req_ready}, 64'd1);
    tick();
    bus.req_valid = 3'b000;
    @(negedge clk);
    chk("t1_rf_we", {63'd0, bus.rf_we}, 64'd1);
    chk("t1_bypass_stall", {63'd0, bus.issue_stall}, 64'd0);
    chk("t1_wb_err", {63'd0, bus.wb_err}, 64'd0);
    tick();
    issue(1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
    @(negedge clk);
    chk("t1_busy_after", bus.busy, 64'd1 << 10);

    // 2: round-robin rotation, then 2,0 order from rr_ptr=1
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 6'(11 + i), 32'h100 + 32'(i));
    bus.req_valid = 3'b111;
    for (int c = 0; c < 4; c++) begin
      gq.push_back(3'b001 << (c % 3));
      wq.push_back({6'(11 + c % 3), 32'h100 + 32'(c % 3)});
      tick();
    end
    bus.req_valid = 3'b101;
    gq.push_back(3'b100);
    wq.push_back({6'd13, 32'h102});
    tick();
    gq.push_back(3'b001);
    wq.push_back({6'd11, 32'h100});
    tick();
    bus.req_valid = 3'b000;
    tick();

    // 3: WAW stall and reuse in the writeback cycle
    do_reset();
    issue(1'b1, 6'd7, 6'd0, 6'd0, 6'd0);
    tick();
    set_req(1, 6'd7, 32'h77);
    bus.req_valid = 3'b010;
    gq.push_back(3'b010);
    wq.push_back({6'd7, 32'h77});
    @(negedge clk);
    chk("waw_stall", {63'd0, bus.issue_stall}, 64'd1);
    tick();
    bus.req_valid = 3'b000;
    @(negedge clk);
    chk("waw_reuse_stall", {63'd0, bus.issue_stall}, 64'd0);
    tick();
    issue(1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
    @(negedge clk);
    chk("waw_busy7", bus.busy, 64'd1 << 7);
    chk("waw_wb_err", {63'd0, bus.wb_err}, 64'd0);

    // 4: x0 destination/sources and x0 writeback
    do_reset();
    issue(1'b1, 6'd0, 6'd0, 6'd0, 6'd0);
    set_req(0, 6'd0, 32'h1234);
    bus.req_valid = 3'b001;
    gq.push_back(3'b001);
    @(negedge clk);
    chk("x0_stall", {63'd0, bus.issue_stall}, 64'd0);
    chk("x0_ready", {61'd0, bus.req_ready}, 64'd1);
    tick();
    bus.req_valid = 3'b000;
    issue(1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
    @(negedge clk);
    chk("x0_rf_we", {63'd0, bus.rf_we}, 64'd0);
    chk("x0_busy", bus.busy, 64'd0);

    // 5a: flush with x3/x40 busy and a same-cycle handshake to x3
    do_reset();
    issue(1'b1, 6'd3, 6'd0, 6'd0, 6'd0);
    tick();
    issue(1'b1, 6'd40, 6'd0, 6'd0, 6'd0);
    tick();
    issue(1'b1, 6'd20, 6'd0, 6'd0, 6'd0);
    bus.flush = 1'b1;
    set_req(2, 6'd3, 32'hABCD0003);
    bus.req_valid = 3'b100;
    gq.push_back(3'b100);
    wq.push_back({6'd3, 32'hABCD0003});
    @(negedge clk);
    chk("fl_busy_before", bus.busy, (64'd1 << 3) | (64'd1 << 40));
    tick();
    bus.flush = 1'b0;
    bus.req_valid = 3'b000;
    issue(1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
    @(negedge clk);
    chk("fl_busy_cleared", bus.busy, 64'd0);
    chk("fl_rf_we", {63'd0, bus.rf_we}, 64'd1);
    tick();
    // The write landing after the flush targets a now-idle register, so it is flagged.
    @(negedge clk);
    chk("fl_late_write_err", {63'd0, bus.wb_err}, 64'd1);

    // 5b: write to idle x9 during flush is not flagged; without flush it is, and sticks
    do_reset();
    set_req(0, 6'd9, 32'h9);
    bus.req_valid = 3'b001;
    gq.push_back(3'b001);
    wq.push_back({6'd9, 32'h9});
    tick();
    bus.req_valid = 3'b000;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("err_masked_by_flush", {63'd0, bus.wb_err}, 64'd0);
    tick();
    bus.req_valid = 3'b001;
    gq.push_back(3'b001);
    wq.push_back({6'd9, 32'h9});
    tick();
    bus.req_valid = 3'b000;
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("err_x9_sticky", {63'd0, bus.wb_err}, 64'd1);
      tick();
    end

    // 6: reset asserted in a handshake cycle
    do_reset();
    issue(1'b1, 6'd6, 6'd0, 6'd0, 6'd0);
    set_req(0, 6'd6, 32'h60);
    bus.req_valid = 3'b001;
    gq.push_back(3'b001);
    wq.push_back({6'd6, 32'h60});
    tick();
    issue(1'b1, 6'd21, 6'd0, 6'd0, 6'd0);
    set_req(1, 6'd6, 32'h66);
    bus.req_valid = 3'b010;
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {61'd0, bus.req_ready}, 64'd0);
    tick();
    issue(1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
    @(negedge clk);
    chk("mid_rst_rf_we", {63'd0, bus.rf_we}, 64'd0);
    chk("mid_rst_busy", bus.busy, 64'd0);
    chk("mid_rst_ready2", {61'd0, bus.req_ready}, 64'd0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) set_req(i, 6'd0, 32'h0);
    bus.req_valid = 3'b111;
    gq.push_back(3'b001);
    @(negedge clk);
    chk("mid_rst_ptr0", {61'd0, bus.req_ready}, 64'd1);
    tick();
    bus.req_valid = 3'b000;
    tick();
    tick();

    chk("grant_queue_drained", 64'(gq.size()), 64'd0);
    chk("write_queue_drained", 64'(wq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
